// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection window buffer sequencer.
// Holds the sequencer state encoding and the window geometry constants.
package edge_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_READY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int WIN_ROWS   = 3;
    localparam int WIN_COLS   = 4;
    localparam int WIN_PIXELS = 12;
    localparam int COL_STEP   = 2;

endpackage

// File: rtl/window_addr_gen.sv
// Combinational SRAM address for one window pixel.
// Slots are filled row-major, so slot k maps to window pixel (k/4, k%4).
module window_addr_gen
    import edge_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [15:0]       row_i,
    input  logic [15:0]       col_i,
    input  logic [3:0]        pix_idx_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [31:0] pix_row;
    logic [31:0] pix_col;
    logic [31:0] line_off;
    logic [31:0] offset;

    // The sum wraps modulo 2^ADDR_W, so frames may straddle the top of memory.
    always_comb begin
        pix_row  = 32'(pix_idx_i) / 32'(WIN_COLS);
        pix_col  = 32'(pix_idx_i) % 32'(WIN_COLS);
        line_off = (32'(row_i) + pix_row) * 32'(IMG_W);
        offset   = line_off + 32'(col_i) + pix_col;
        addr_o   = base_i + ADDR_W'(offset);
    end

endmodule

// File: rtl/buffer_fill_ctrl.sv
// Walks a 3x4 window across the image, fetching one pixel per accepted read
// and handing each full window to the compute stage before advancing.
module buffer_fill_ctrl
    import edge_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ready,
    input  logic              proc_done,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              shift_enable,
    output logic              buffer_clear,
    output logic              window_valid,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    localparam logic [15:0] COL_LAST = 16'(IMG_W - WIN_COLS);
    localparam logic [15:0] ROW_LAST = 16'(IMG_H - WIN_ROWS);
    localparam logic [3:0]  PIX_LAST = 4'(WIN_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       row_q, row_d;
    logic [15:0]       col_q, col_d;
    logic [3:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] pix_addr;
    logic              aborting;

    window_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base_i    (base_q),
        .row_i     (row_q),
        .col_i     (col_q),
        .pix_idx_i (pix_q),
        .addr_o    (pix_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
        end
    end

    assign aborting = abort && (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        row_d   = row_q;
        col_d   = col_q;
        pix_d   = pix_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pix_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    pix_d = pix_q + 4'd1;
                    if (pix_q == PIX_LAST) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (proc_done) begin
                    if (col_q < COL_LAST) begin
                        col_d   = col_q + 16'(COL_STEP);
                        state_d = S_CLEAR;
                    end else if (row_q < ROW_LAST) begin
                        col_d   = '0;
                        row_d   = row_q + 16'd1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition; the buffer is cleared on the way out.
        if (aborting) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        mem_read     = (state_q == S_FETCH) && !aborting;
        mem_addr     = mem_read ? pix_addr : '0;
        shift_enable = mem_read && mem_ready;
        buffer_clear = (state_q == S_CLEAR) || aborting;
        window_valid = (state_q == S_READY);
        win_row      = (state_q == S_IDLE) ? 16'd0 : row_q;
        win_col      = (state_q == S_IDLE) ? 16'd0 : col_q;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE) && !aborting;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// Directed bench for buffer_fill_ctrl with IMG_W=8, IMG_H=4, ADDR_W=16.
// Expected addresses are queued per window and popped as reads are accepted.
module tb_buffer_fill_ctrl;
    import edge_pkg::*;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              mem_ready = 1'b1;
    logic              proc_done = 1'b0;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic              shift_enable;
    logic              buffer_clear;
    logic              window_valid;
    logic [15:0]       win_row;
    logic [15:0]       win_col;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [ADDR_W-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    buffer_fill_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .mem_ready    (mem_ready),
        .proc_done    (proc_done),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .shift_enable (shift_enable),
        .buffer_clear (buffer_clear),
        .window_valid (window_valid),
        .win_row      (win_row),
        .win_col      (win_col),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_read"},  32'(mem_read), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_shift"}, 32'(shift_enable), 32'd0);
        chk({tag, "_clear"}, 32'(buffer_clear), 32'd0);
        chk({tag, "_valid"}, 32'(window_valid), 32'd0);
        chk({tag, "_row"},   32'(win_row), 32'd0);
        chk({tag, "_col"},   32'(win_col), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
        base_addr = 16'hDEAD;
        #1;
        chk("start_clear", 32'(buffer_clear), 32'd1);
        chk("start_read",  32'(mem_read), 32'd0);
        chk("start_state", 32'(dbg_state), 32'(S_CLEAR));
    endtask

    // Entered in the CLEAR cycle; leaves the bench sitting in the READY cycle.
    task automatic fetch_window(input logic [15:0] row, input logic [15:0] col,
                                input logic [ADDR_W-1:0] first, input int stall_pix,
                                input int stall_n);
        int c0;
        logic [ADDR_W-1:0] e;
        c0 = cyc;
        exp_q.delete();
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(first + 16'((k / 4) * IMG_W + (k % 4)));
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == stall_pix) begin
                for (int s = 0; s < stall_n; s++) begin
                    mem_ready = 1'b0;
                    #1;
                    chk("stall_read",  32'(mem_read), 32'd1);
                    chk("stall_addr",  32'(mem_addr), 32'(exp_q[0]));
                    chk("stall_shift", 32'(shift_enable), 32'd0);
                    tick();
                end
            end
            mem_ready = 1'b1;
            #1;
            e = exp_q.pop_front();
            chk("fetch_addr",  32'(mem_addr), 32'(e));
            chk("fetch_read",  32'(mem_read), 32'd1);
            chk("fetch_shift", 32'(shift_enable), 32'd1);
            chk("fetch_valid", 32'(window_valid), 32'd0);
        end
        tick();
        chk("ready_valid", 32'(window_valid), 32'd1);
        chk("ready_row",   32'(win_row), 32'(row));
        chk("ready_col",   32'(win_col), 32'(col));
        chk("ready_shift", 32'(shift_enable), 32'd0);
        chk("ready_read",  32'(mem_read), 32'd0);
        chk("window_len",  32'(cyc - c0), 32'(13 + stall_n));
    endtask

    task automatic finish_window(input bit last);
        tick();
        chk("hold_valid", 32'(window_valid), 32'd1);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        #1;
        if (!last) begin
            chk("next_clear", 32'(buffer_clear), 32'd1);
            chk("next_done",  32'(done), 32'd0);
        end else begin
            chk("last_done",  32'(done), 32'd1);
            chk("last_busy",  32'(busy), 32'd1);
            chk("last_valid", 32'(window_valid), 32'd0);
            tick();
            chk("post_done", 32'(done), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic abort_now();
        abort = 1'b1;
        #1;
        chk("abort_clear", 32'(buffer_clear), 32'd1);
        chk("abort_read",  32'(mem_read), 32'd0);
        chk("abort_shift", 32'(shift_enable), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        tick();
        abort = 1'b0;
        #1;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    endtask

    logic [15:0] frame_row  [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
    logic [15:0] frame_col  [6] = '{16'd0, 16'd2, 16'd4, 16'd0, 16'd2, 16'd4};
    logic [15:0] frame_addr [6] = '{16'h0100, 16'h0102, 16'h0104, 16'h0108, 16'h010A, 16'h010C};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle behaviour; mem_ready is high but must be ignored.
        #2;
        chk_quiet("in_reset");
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_quiet("reset");
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        #1;
        chk_quiet("idle_proc_done");
        abort = 1'b1;
        #1;
        chk_quiet("idle_abort");
        tick();
        abort = 1'b0;
        #1;
        chk_quiet("idle_after_abort");

        // Full frame of six windows.
        start_frame(16'h0100);
        for (int w = 0; w < 6; w++) begin
            fetch_window(frame_row[w], frame_col[w], frame_addr[w], -1, 0);
            finish_window(w == 5);
        end
        chk_quiet("frame_end");

        // Three-cycle stall on pixel 5, then abort out of READY.
        start_frame(16'h0100);
        fetch_window(16'd0, 16'd0, 16'h0100, 5, 3);
        abort_now();

        // Abort in FETCH at pixel 7; a late mem_ready must not shift.
        start_frame(16'h0100);
        for (int k = 0; k < 7; k++) begin
            tick();
            #1;
            chk("pre_abort_shift", 32'(shift_enable), 32'd1);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        chk("abort_pix7_addr", 32'(mem_addr), 32'h010B);
        abort_now();
        mem_ready = 1'b1;
        #1;
        chk("late_ready_shift", 32'(shift_enable), 32'd0);
        chk("late_ready_read",  32'(mem_read), 32'd0);
        tick();
        chk_quiet("late_ready_idle");

        // Restart after abort begins again at the first window.
        start_frame(16'h0100);
        fetch_window(16'd0, 16'd0, 16'h0100, -1, 0);
        abort_now();

        // Address wrap at the top of the 16-bit space.
        start_frame(16'hFFFC);
        fetch_window(16'd0, 16'd0, 16'hFFFC, -1, 0);
        abort_now();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
